// File: rtl/accel_mem_pkg.sv
// Shared types and constants for the accelerator memory initiator.
// Optional stall timeout is enabled by defining ACCEL_MEM_TIMEOUT_EN.
package accel_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWr,
        StDone
    } state_e;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned STORE_WORDS = 8;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned STORE_BYTES = STORE_WORDS * WORD_BYTES;

    // True when the whole access footprint fits below mem_size, so 16-bit address math never wraps.
    function automatic logic cmd_in_range(input logic op, input logic [15:0] addr,
                                          input int unsigned mem_size);
        int unsigned span;
        span = (op == OP_LOAD) ? BLOCK_BYTES : STORE_BYTES;
        return (mem_size >= span) && ({16'd0, addr} <= mem_size - span);
    endfunction

endpackage

// File: rtl/accel_mem_stall_timer.sv
// Counts consecutive stalled request cycles; expire pulses on the stall that reaches LIMIT.
// Only instantiated when ACCEL_MEM_TIMEOUT_EN is defined.
module accel_mem_stall_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CntW = $clog2(LIMIT + 1);

    logic [CntW-1:0] cnt_q;

    assign expire = count && (cnt_q == CntW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || expire) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/accel_mem_initiator.sv
// Accelerator data-memory initiator: one 512-bit block LOAD or eight-word STORE per command.
// Define ACCEL_MEM_TIMEOUT_EN to abort commands stalled for TIMEOUT_CYCLES consecutive cycles.
module accel_mem_initiator
    import accel_mem_pkg::*;
#(
    parameter int unsigned MEM_SIZE       = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [15:0]  base_addr,
    input  logic [255:0] st_data,
    input  logic         cpu_mem_busy,
    input  logic [511:0] accel_rd_data,
    output logic [15:0]  accel_addr,
    output logic [31:0]  accel_wrt_data,
    output logic         accel_wrt_en,
    output logic         accel_rd_en,
    output logic [511:0] ld_block,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_e         state_q;
    logic [2:0]     idx_q;
    logic [2:0]     idx_nxt;
    logic [255:0]   st_data_q;
    logic           stall;
    logic           stall_expire;

    assign idx_nxt = idx_q + 3'd1;
    assign stall   = cpu_mem_busy && ((state_q == StRdReq) || (state_q == StWr));

`ifdef ACCEL_MEM_TIMEOUT_EN
    accel_mem_stall_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .count  (stall),
        .clear  (!stall),
        .expire (stall_expire)
    );
`else
    // Stalls wait indefinitely; the limit has no effect in this build.
    localparam bit TimeoutIgnored = (TIMEOUT_CYCLES != 0);
    assign stall_expire = 1'b0 & TimeoutIgnored & stall;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            st_data_q      <= '0;
            accel_addr     <= '0;
            accel_wrt_data <= '0;
            accel_wrt_en   <= 1'b0;
            accel_rd_en    <= 1'b0;
            ld_block       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy       <= 1'b1;
                        st_data_q  <= st_data;
                        accel_addr <= base_addr;
                        if (!cmd_in_range(op, base_addr, MEM_SIZE)) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else if (op == OP_LOAD) begin
                            state_q     <= StRdReq;
                            accel_rd_en <= 1'b1;
                        end else begin
                            state_q        <= StWr;
                            accel_wrt_en   <= 1'b1;
                            accel_wrt_data <= st_data[31:0];
                            idx_q          <= '0;
                        end
                    end
                end
                StRdReq: begin
                    if (!cpu_mem_busy) begin
                        accel_rd_en <= 1'b0;
                        state_q     <= StRdWait;
                    end else if (stall_expire) begin
                        accel_rd_en <= 1'b0;
                        state_q     <= StDone;
                        done        <= 1'b1;
                        err         <= 1'b1;
                    end
                end
                StRdWait: begin
                    ld_block <= accel_rd_data;
                    state_q  <= StDone;
                    done     <= 1'b1;
                end
                StWr: begin
                    // Address, data and index only move on a serviced write.
                    if (!cpu_mem_busy) begin
                        if (idx_q == 3'(STORE_WORDS - 1)) begin
                            accel_wrt_en <= 1'b0;
                            state_q      <= StDone;
                            done         <= 1'b1;
                        end else begin
                            idx_q          <= idx_nxt;
                            accel_addr     <= accel_addr + 16'(WORD_BYTES);
                            accel_wrt_data <= st_data_q[{idx_nxt, 5'd0} +: 32];
                        end
                    end else if (stall_expire) begin
                        accel_wrt_en <= 1'b0;
                        state_q      <= StDone;
                        done         <= 1'b1;
                        err          <= 1'b1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    accel_rd_en  <= 1'b0;
                    accel_wrt_en <= 1'b0;
                    busy         <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_mem_initiator.sv
// Randomized self-checking bench for accel_mem_initiator with a per-command trace model.
// Honours ACCEL_MEM_TIMEOUT_EN the same way the design does.
module tb_accel_mem_initiator;
    import accel_mem_pkg::*;

    localparam int unsigned MEM = 65536;
    localparam int          TO  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [15:0]  base_addr;
    logic [255:0] st_data;
    logic         cpu_mem_busy;
    logic [511:0] accel_rd_data;
    logic [15:0]  accel_addr;
    logic [31:0]  accel_wrt_data;
    logic         accel_wrt_en;
    logic         accel_rd_en;
    logic [511:0] ld_block;
    logic         busy;
    logic         done;
    logic         err;

    accel_mem_initiator #(
        .MEM_SIZE       (MEM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .op             (op),
        .base_addr      (base_addr),
        .st_data        (st_data),
        .cpu_mem_busy   (cpu_mem_busy),
        .accel_rd_data  (accel_rd_data),
        .accel_addr     (accel_addr),
        .accel_wrt_data (accel_wrt_data),
        .accel_wrt_en   (accel_wrt_en),
        .accel_rd_en    (accel_rd_en),
        .ld_block       (ld_block),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         busy, done, err, rd_en, wrt_en;
        logic         chk_addr, chk_wdata, chk_err;
        logic [15:0]  addr;
        logic [31:0]  wdata;
        logic [511:0] ld;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur;
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           start_at = 0;
    int           done_at = -1;
    int           rd_seen = 0;
    logic         done_err;
    logic [15:0]  wlog_a[$];
    logic [31:0]  wlog_d[$];
    logic [511:0] ld_model;
    int           stl[8];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0; e.rd_en = 1'b0; e.wrt_en = 1'b0;
        e.chk_addr = 1'b0; e.chk_wdata = 1'b0; e.chk_err = 1'b0;
        e.addr = '0; e.wdata = '0; e.ld = ld_model;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e = idle_exp();
        e.chk_addr = 1'b1; e.chk_wdata = 1'b1; e.chk_err = 1'b1; e.ld = '0;
        return e;
    endfunction

    // Single compare process: one expectation per clock once stimulus is running.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (accel_rd_en === 1'b1) rd_seen++;
        if (accel_wrt_en === 1'b1) begin
            wlog_a.push_back(accel_addr);
            wlog_d.push_back(accel_wrt_data);
        end
        if (done === 1'b1) begin
            done_at  = cyc;
            done_err = err;
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("busy", 512'(busy), 512'(cur.busy));
            check("done", 512'(done), 512'(cur.done));
            check("rd_en", 512'(accel_rd_en), 512'(cur.rd_en));
            check("wrt_en", 512'(accel_wrt_en), 512'(cur.wrt_en));
            check("ld_block", ld_block, cur.ld);
            if (cur.chk_addr) check("addr", 512'(accel_addr), 512'(cur.addr));
            if (cur.chk_wdata) check("wdata", 512'(accel_wrt_data), 512'(cur.wdata));
            if (cur.chk_err) check("err", 512'(err), 512'(cur.err));
        end
    end

    task automatic do_reset(input int n);
        ld_model = '0;
        repeat (n) begin
            @(negedge clk);
            rst_n = 1'b0;
            start = 1'($urandom);
            cpu_mem_busy = 1'($urandom);
            exp_q.push_back(zero_exp());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n = 1'b1;
            start = 1'b0;
            op = 1'($urandom);
            base_addr = 16'($urandom);
            st_data = rnd256();
            cpu_mem_busy = 1'($urandom);
            accel_rd_data = rnd512();
            exp_q.push_back(idle_exp());
        end
    endtask

    // Builds the whole expected trace of one command from its stall plan, then plays it.
    task automatic run_cmd(input logic o, input logic [15:0] base, input logic [255:0] data,
                           input int stalls[8], input logic [511:0] rdv, input int abort_at);
        logic         cb[64];
        logic [511:0] rdd[64];
        exp_t         e[64];
        int           t, done_t, s;
        int unsigned  baddr;
        logic         ok, ab_err;
        logic [511:0] new_ld;
        new_ld = ld_model;
        ab_err = 1'b0;
        baddr  = {16'd0, base};
        for (int i = 0; i < 64; i++) begin
            cb[i]  = 1'($urandom);
            rdd[i] = rnd512();
            e[i]   = idle_exp();
            e[i].busy = 1'b1;
        end
        ok = (o == OP_LOAD) ? (baddr <= MEM - 64) : (baddr <= MEM - 32);
        if (!ok) begin
            done_t = 1;
            ab_err = 1'b1;
        end else if (o == OP_LOAD) begin
            s = stalls[0];
`ifdef ACCEL_MEM_TIMEOUT_EN
            if (s >= TO) begin
                for (t = 1; t <= TO; t++) begin
                    cb[t] = 1'b1; e[t].rd_en = 1'b1; e[t].chk_addr = 1'b1; e[t].addr = base;
                end
                done_t = TO + 1;
                ab_err = 1'b1;
            end else
`endif
            begin
                for (t = 1; t <= s + 1; t++) begin
                    cb[t] = (t <= s); e[t].rd_en = 1'b1; e[t].chk_addr = 1'b1; e[t].addr = base;
                end
                rdd[s + 2] = rdv;
                done_t = s + 3;
                new_ld = rdv;
            end
        end else begin
            t = 1;
            for (int w = 0; w < 8; w++) begin
                for (int k = 0; k <= stalls[w]; k++) begin
                    cb[t] = (k < stalls[w]);
                    e[t].wrt_en = 1'b1;
                    e[t].chk_addr = 1'b1;  e[t].addr = base + 16'(4 * w);
                    e[t].chk_wdata = 1'b1; e[t].wdata = data[32*w +: 32];
                    t++;
                end
            end
            done_t = t;
        end
        e[done_t].done = 1'b1;
        e[done_t].err = ab_err;
        e[done_t].chk_err = 1'b1;
        e[done_t].ld = new_ld;
        ld_model = new_ld;
        e[done_t + 1] = idle_exp();

        for (t = 0; t <= done_t; t++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if (t == 0) begin
                start = 1'b1; op = o; base_addr = base; st_data = data;
                start_at = cyc;
            end else begin
                // Starts while busy (including the done cycle) must be ignored.
                start = 1'($urandom); op = 1'($urandom);
                base_addr = 16'($urandom); st_data = rnd256();
            end
            cpu_mem_busy = cb[t];
            accel_rd_data = rdd[t];
            if (t == abort_at) begin
                rst_n = 1'b0;
                ld_model = '0;
                exp_q.push_back(zero_exp());
                return;
            end
            exp_q.push_back(e[t + 1]);
        end
    endtask

    task automatic clr_stalls();
        for (int i = 0; i < 8; i++) stl[i] = 0;
    endtask

    task automatic clr_logs();
        rd_seen = 0;
        wlog_a.delete();
        wlog_d.delete();
    endtask

    logic [255:0] sdata;
    logic [511:0] a5;
    int           n208, nuniq, prev_done;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 1'b0; base_addr = '0; st_data = '0;
        cpu_mem_busy = 1'b0; accel_rd_data = '0;
        do_reset(2);
        idle(2);

        // Uncontended LOAD.
        clr_stalls(); clr_logs();
        a5 = {64{8'hA5}};
        run_cmd(OP_LOAD, 16'h0100, rnd256(), stl, a5, -1);
        idle(1);
        check("load_latency", 512'(done_at - start_at), 512'd3);
        check("load_err", 512'(done_err), 512'd0);
        check("load_block", ld_block, a5);
        check("load_rd_count", 512'(rd_seen), 512'd1);

        // Uncontended STORE.
        clr_logs();
        sdata = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
        run_cmd(OP_STORE, 16'h0200, sdata, stl, '0, -1);
        idle(1);
        check("store_latency", 512'(done_at - start_at), 512'd9);
        check("store_wr_count", 512'(wlog_a.size()), 512'd8);
        check("store_addr0", 512'(wlog_a[0]), 512'h0200);
        check("store_addr7", 512'(wlog_a[7]), 512'h021C);
        check("store_data0", 512'(wlog_d[0]), 512'h11111111);
        check("store_data7", 512'(wlog_d[7]), 512'h88888888);

        // STORE with word 2 stalled three cycles.
        clr_logs();
        stl[2] = 3;
        run_cmd(OP_STORE, 16'h0200, sdata, stl, '0, -1);
        idle(1);
        n208 = 0; nuniq = 0;
        for (int i = 0; i < wlog_a.size(); i++) begin
            if (wlog_a[i] == 16'h0208) n208++;
            if (i == 0 || wlog_a[i] != wlog_a[i - 1]) nuniq++;
        end
        check("stall_latency", 512'(done_at - start_at), 512'd12);
        check("stall_hold_0208", 512'(n208), 512'd4);
        check("stall_distinct_words", 512'(nuniq), 512'd8);
        clr_stalls();

        // Range boundaries.
        clr_logs();
        run_cmd(OP_LOAD, 16'hFFC1, rnd256(), stl, rnd512(), -1);
        check("oob_load_latency", 512'(done_at - start_at), 512'd1);
        check("oob_load_err", 512'(done_err), 512'd1);
        check("oob_load_no_rd", 512'(rd_seen), 512'd0);
        run_cmd(OP_LOAD, 16'hFFC0, rnd256(), stl, rnd512(), -1);
        check("edge_load_err", 512'(done_err), 512'd0);
        run_cmd(OP_STORE, 16'hFFE0, rnd256(), stl, '0, -1);
        check("edge_store_latency", 512'(done_at - start_at), 512'd9);
        check("edge_store_err", 512'(done_err), 512'd0);
        clr_logs();
        run_cmd(OP_STORE, 16'hFFE1, rnd256(), stl, '0, -1);
        check("oob_store_err", 512'(done_err), 512'd1);
        check("oob_store_no_wr", 512'(wlog_a.size()), 512'd0);
        idle(1);

        // LOAD stuck behind the CPU for six cycles.
        clr_logs();
        stl[0] = 6;
        run_cmd(OP_LOAD, 16'h0040, rnd256(), stl, rnd512(), -1);
        idle(1);
`ifdef ACCEL_MEM_TIMEOUT_EN
        check("timeout_latency", 512'(done_at - start_at), 512'd5);
        check("timeout_err", 512'(done_err), 512'd1);
        check("timeout_rd_cycles", 512'(rd_seen), 512'd4);
`else
        check("no_timeout_latency", 512'(done_at - start_at), 512'd9);
        check("no_timeout_err", 512'(done_err), 512'd0);
        check("no_timeout_rd_cycles", 512'(rd_seen), 512'd7);
`endif
        clr_stalls();

        // Reset while word 4 of a STORE is on the bus.
        prev_done = done_at;
        run_cmd(OP_STORE, 16'h0300, rnd256(), stl, '0, 5);
        idle(3);
        check("reset_no_done", 512'(done_at), 512'(prev_done));
        a5 = rnd512();
        run_cmd(OP_LOAD, 16'h0400, rnd256(), stl, a5, -1);
        idle(1);
        check("post_reset_latency", 512'(done_at - start_at), 512'd3);
        check("post_reset_block", ld_block, a5);

        // Randomized commands, stalls and gaps.
        for (int n = 0; n < 40; n++) begin
            logic        o;
            logic [15:0] b;
            o = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                b = (o ? 16'hFFDE : 16'hFFBE) + 16'($urandom_range(0, 4));
            else
                b = 16'($urandom);
            for (int i = 0; i < 8; i++)
                stl[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            run_cmd(o, b, rnd256(), stl, rnd512(), -1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
